hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter: MULT_CYCLES, default 4, busy cycles of a multiply (range 1..63).
REQ-002 Parameter: DIV_CYCLES, default 32, busy cycles of a divide (range 1..63).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rs_d, rt_d  in  5 each  source register numbers of the instruction in decode.
REQ-006 rs_e, rt_e  in  5 each  source register numbers of the instruction in execute.
REQ-007 write_reg_e, write_reg_m, write_reg_w  in  5 each  destination register per stage.
REQ-008 reg_write_e, reg_write_m, reg_write_w  in  1 each  destination write enable per stage.
REQ-009 mem_to_reg_e, mem_to_reg_m  in  1 each  instruction in that stage is a load.
REQ-010 branch_d  in  1  decode holds a branch comparing rs_d/rt_d.
REQ-011 md_op_d, mfhilo_d  in  1 each  decode holds a mult/div, or an mfhi/mflo.
REQ-012 md_start_e, md_is_div_e  in  1 each  mult/div enters execute this cycle; 1 = divide, 0 = multiply.
REQ-013 forward_a_e, forward_b_e  out  2 each  execute operand select: 00 register file, 01 result_w, 10 alu_out_m.
REQ-014 forward_a_d, forward_b_d  out  1 each  decode branch-compare operand taken from alu_out_m.
REQ-015 stall_f, stall_d, flush_e  out  1 each  hold fetch, hold decode, bubble execute.
REQ-016 md_busy, md_done  out  1 each  unit in BUSY; one-cycle completion pulse (HI/LO write).

Function
REQ-017 forward_a_e = 10 when reg_write_m, write_reg_m != 0 and write_reg_m == rs_e; else 01 when reg_write_w, write_reg_w != 0 and write_reg_w == rs_e; else 00. M has priority over W.
REQ-018 forward_b_e uses the same rule with rt_e; 11 is never driven.
REQ-019 forward_a_d = reg_write_m & (write_reg_m != 0) & (write_reg_m == rs_d); forward_b_d is the same with rt_d.
REQ-020 lw_stall = mem_to_reg_e & reg_write_e & (write_reg_e != 0) & (write_reg_e == rs_d | write_reg_e == rt_d).
REQ-021 br_stall = branch_d & ((reg_write_e & write_reg_e != 0 & write_reg_e matches rs_d or rt_d) | (mem_to_reg_m & write_reg_m != 0 & write_reg_m matches rs_d or rt_d)).
REQ-022 The mult/div sequencer FSM has three states: IDLE, BUSY and DONE, with a 6-bit down-counter.
REQ-023 IDLE with md_start_e: load count = (md_is_div_e ? DIV_CYCLES : MULT_CYCLES) - 1, go to BUSY.
REQ-024 BUSY: if count == 0, go to DONE; else decrement count.
REQ-025 DONE lasts exactly one cycle, then returns to IDLE.
REQ-026 Timing: a start sampled at edge t gives BUSY for cycles t+1..t+N and DONE in cycle t+N+1, where N is the selected cycle count.
REQ-027 md_start_e is ignored in BUSY or DONE; the bench flags it as a protocol error.
REQ-028 md_busy = (state == BUSY) and md_done = (state == DONE); both decode directly from state registers.
REQ-029 md_stall = (md_op_d | mfhilo_d) & (state == BUSY | (state == IDLE & md_start_e)).
REQ-030 Decode is not stalled by the sequencer while in DONE.
REQ-031 stall_f = stall_d = flush_e = lw_stall | br_stall | md_stall.
REQ-032 All forwarding and stall outputs are combinational; zero-cycle latency from inputs.
REQ-033 Register 0 never forwards and never causes a stall.
REQ-034 Simultaneous hazards OR together; no hazard masks another.

Reset
REQ-035 reset asserted forces state = IDLE, count = 0, md_busy = 0 and md_done = 0 immediately, without waiting for clk.
REQ-036 Reset mid-BUSY abandons the operation; no md_done pulse follows deassertion.
REQ-037 The first rising edge after reset deassertion may accept md_start_e.

Verification
REQ-038 reg_write_m = 1, write_reg_m = 8, reg_write_w = 1, write_reg_w = 8, rs_e = 8 -> forward_a_e = 10; clear reg_write_m -> 01; set write_reg_m = write_reg_w = 0 -> 00.
REQ-039 mem_to_reg_e = 1, reg_write_e = 1, write_reg_e = 9, rt_d = 9 -> stall_f = stall_d = flush_e = 1 for that cycle only; with write_reg_e = 0 -> all 0.
REQ-040 branch_d = 1, reg_write_e = 1, write_reg_e = 4, rs_d = 4 -> stall asserted; next cycle, with the producer in M as a non-load -> no stall and forward_a_d = 1.
REQ-041 md_start_e with md_is_div_e = 1 at edge t, mfhilo_d held at 1 -> md_busy high for 32 cycles, md_done high in cycle t+33, stall deasserted in cycle t+33.
REQ-042 Multiply start, then reset asserted in the 2nd BUSY cycle -> md_busy drops asynchronously, no md_done pulse; a new multiply is accepted after release and md_done appears 5 cycles after its start edge.

Source files
------------

// File: rtl/hazard_controller.sv
// Pipeline hazard unit: operand forwarding for execute and branch compare, stall/flush
// generation, and a multi-cycle mult/div sequencer that gates HI/LO consumers.
module hazard_controller #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] write_reg_e,
  input  logic [4:0] write_reg_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_e,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       mem_to_reg_e,
  input  logic       mem_to_reg_m,
  input  logic       branch_d,
  input  logic       md_op_d,
  input  logic       mfhilo_d,
  input  logic       md_start_e,
  input  logic       md_is_div_e,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       forward_a_d,
  output logic       forward_b_d,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_e,
  output logic       md_busy,
  output logic       md_done
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

  md_state_e  state_q;
  logic [5:0] count_q;

  logic m_valid, w_valid, e_valid;
  logic lw_stall, br_stall, md_stall, any_stall;

  // Register 0 is hard-wired zero, so a write to it is never a real producer.
  assign e_valid = reg_write_e & (write_reg_e != 5'd0);
  assign m_valid = reg_write_m & (write_reg_m != 5'd0);
  assign w_valid = reg_write_w & (write_reg_w != 5'd0);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if (m_valid && write_reg_m == rs_e)      forward_a_e = 2'b10;
    else if (w_valid && write_reg_w == rs_e) forward_a_e = 2'b01;
    if (m_valid && write_reg_m == rt_e)      forward_b_e = 2'b10;
    else if (w_valid && write_reg_w == rt_e) forward_b_e = 2'b01;
  end

  assign forward_a_d = m_valid & (write_reg_m == rs_d);
  assign forward_b_d = m_valid & (write_reg_m == rt_d);

  assign lw_stall = mem_to_reg_e & e_valid & ((write_reg_e == rs_d) | (write_reg_e == rt_d));

  // A branch resolves in decode, so any in-flight producer in E, or a load still in M, must drain.
  assign br_stall = branch_d &
                    ((e_valid & ((write_reg_e == rs_d) | (write_reg_e == rt_d))) |
                     (mem_to_reg_m & (write_reg_m != 5'd0) &
                      ((write_reg_m == rs_d) | (write_reg_m == rt_d))));

  assign md_stall = (md_op_d | mfhilo_d) &
                    ((state_q == BUSY) | ((state_q == IDLE) & md_start_e));

  assign any_stall = lw_stall | br_stall | md_stall;
  assign stall_f   = any_stall;
  assign stall_d   = any_stall;
  assign flush_e   = any_stall;

  assign md_busy = (state_q == BUSY);
  assign md_done = (state_q == DONE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 6'd0;
    end else begin
      case (state_q)
        IDLE: if (md_start_e) begin
          count_q <= md_is_div_e ? DIV_LOAD : MULT_LOAD;
          state_q <= BUSY;
        end
        BUSY: begin
          if (count_q == 6'd0) state_q <= DONE;
          else                 count_q <= count_q - 6'd1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed vector table, multi-cycle
// sequencer/reset sequences, and randomized traffic against a behavioural model.
module tb_hazard_controller;

  localparam int MULT_N = 4;
  localparam int DIV_N  = 32;

  typedef struct {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic       rw_e, rw_m, rw_w, m2r_e, m2r_m, br, md_op, mfhilo;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [1:0] fa_e, fb_e;
    logic       fa_d, fb_d, stall;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
  logic       branch_d, md_op_d, mfhilo_d, md_start_e, md_is_div_e;
  logic [1:0] forward_a_e, forward_b_e;
  logic       forward_a_d, forward_b_d, stall_f, stall_d, flush_e, md_busy, md_done;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  hazard_controller #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
    .branch_d(branch_d), .md_op_d(md_op_d), .mfhilo_d(mfhilo_d),
    .md_start_e(md_start_e), .md_is_div_e(md_is_div_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A new mult/div while the unit is occupied is a protocol violation by the stimulus.
  always @(posedge clk) begin
    if (!reset && md_start_e && (md_busy || md_done)) begin
      errors++;
      $display("FAIL md_start_protocol: start while busy=%0b done=%0b", md_busy, md_done);
    end
  end

  task automatic apply(input in_t x);
    rs_d = x.rs_d;  rt_d = x.rt_d;  rs_e = x.rs_e;  rt_e = x.rt_e;
    write_reg_e = x.wr_e;  write_reg_m = x.wr_m;  write_reg_w = x.wr_w;
    reg_write_e = x.rw_e;  reg_write_m = x.rw_m;  reg_write_w = x.rw_w;
    mem_to_reg_e = x.m2r_e;  mem_to_reg_m = x.m2r_m;
    branch_d = x.br;  md_op_d = x.md_op;  mfhilo_d = x.mfhilo;
  endtask

  task automatic add(input string n, input in_t x, input logic [1:0] a, input logic [1:0] b,
                     input logic ad, input logic bd, input logic s);
    vec_t v;
    v.name = n; v.in = x; v.fa_e = a; v.fb_e = b; v.fa_d = ad; v.fb_d = bd; v.stall = s;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: forwarding source for one operand, written from the priority rules.
  function automatic logic [1:0] ref_fwd(input in_t x, input logic [4:0] src);
    if (src == 5'd0) return 2'd0;
    if (x.rw_m && x.wr_m == src) return 2'd2;
    if (x.rw_w && x.wr_w == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic ref_stall(input in_t x, input logic unit_busy, input logic starting);
    logic reads_e, reads_m;
    reads_e = (x.wr_e != 0) && (x.wr_e == x.rs_d || x.wr_e == x.rt_d);
    reads_m = (x.wr_m != 0) && (x.wr_m == x.rs_d || x.wr_m == x.rt_d);
    return (x.m2r_e && x.rw_e && reads_e) ||
           (x.br && ((x.rw_e && reads_e) || (x.m2r_m && reads_m))) ||
           ((x.md_op || x.mfhilo) && (unit_busy || starting));
  endfunction

  function automatic in_t rand_in();
    in_t x;
    x.rs_d = 5'($urandom_range(0, 3));  x.rt_d = 5'($urandom_range(0, 3));
    x.rs_e = 5'($urandom_range(0, 3));  x.rt_e = 5'($urandom_range(0, 3));
    x.wr_e = 5'($urandom_range(0, 3));  x.wr_m = 5'($urandom_range(0, 3));
    x.wr_w = 5'($urandom_range(0, 3));
    x.rw_e = 1'($urandom_range(0, 1));  x.rw_m = 1'($urandom_range(0, 1));
    x.rw_w = 1'($urandom_range(0, 1));  x.m2r_e = 1'($urandom_range(0, 1));
    x.m2r_m = 1'($urandom_range(0, 1)); x.br = 1'($urandom_range(0, 1));
    x.md_op = 1'($urandom_range(0, 1)); x.mfhilo = 1'($urandom_range(0, 1));
    return x;
  endfunction

  initial begin
    in_t t, z;
    int busy_n, first_busy, done_k, stall_bad, any_n;
    logic stall_at_done;
    int m_left;
    logic m_done, idle, st, dv;

    z = '{default: '0};
    apply(z);
    md_start_e = 1'b0;
    md_is_div_e = 1'b0;
    reset = 1'b1;
    #2;
    check("reset_busy", 32'(md_busy), 32'd0);
    check("reset_done", 32'(md_done), 32'd0);
    check("reset_stall", 32'(stall_f), 32'd0);
    tick();
    reset = 1'b0;

    // Directed combinational vectors; the sequencer stays idle throughout.
    add("idle", z, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    t = '{rs_e: 5'd8, wr_m: 5'd8, rw_m: 1'b1, wr_w: 5'd8, rw_w: 1'b1, default: '0};
    add("fwd_m_over_w", t, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
    t.rw_m = 1'b0;
    add("fwd_w", t, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    t.rw_m = 1'b1; t.wr_m = 5'd0; t.wr_w = 5'd0;
    add("fwd_r0_none", t, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    t = '{rt_e: 5'd3, wr_w: 5'd3, rw_w: 1'b1, default: '0};
    add("fwd_b_w", t, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0);
    t = '{rs_e: 5'd6, rt_e: 5'd6, wr_m: 5'd6, rw_m: 1'b1, wr_w: 5'd6, rw_w: 1'b1, default: '0};
    add("fwd_both_m", t, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    t = '{m2r_e: 1'b1, rw_e: 1'b1, wr_e: 5'd9, rt_d: 5'd9, default: '0};
    add("lw_stall", t, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    t.wr_e = 5'd0; t.rt_d = 5'd0;
    add("lw_r0_none", t, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    t = '{m2r_e: 1'b1, wr_e: 5'd9, rs_d: 5'd9, default: '0};
    add("lw_no_rw", t, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    t = '{br: 1'b1, m2r_m: 1'b1, rw_m: 1'b1, wr_m: 5'd5, rt_d: 5'd5, default: '0};
    add("br_load_m", t, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    t = '{rw_m: 1'b1, wr_m: 5'd4, rs_d: 5'd4, default: '0};
    add("fwd_a_d", t, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    t = '{md_op: 1'b1, mfhilo: 1'b1, default: '0};
    add("md_idle_nostall", t, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    t = '{m2r_e: 1'b1, rw_e: 1'b1, wr_e: 5'd7, rs_d: 5'd7, br: 1'b1, rt_d: 5'd2,
          rs_e: 5'd7, wr_w: 5'd7, rw_w: 1'b1, default: '0};
    add("lw_br_combo", t, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1);

    foreach (vq[i]) begin
      apply(vq[i].in);
      #1;
      check({vq[i].name, ".fa_e"}, 32'(forward_a_e), 32'(vq[i].fa_e));
      check({vq[i].name, ".fb_e"}, 32'(forward_b_e), 32'(vq[i].fb_e));
      check({vq[i].name, ".fa_d"}, 32'(forward_a_d), 32'(vq[i].fa_d));
      check({vq[i].name, ".fb_d"}, 32'(forward_b_d), 32'(vq[i].fb_d));
      check({vq[i].name, ".stall"}, 32'({stall_f, stall_d, flush_e}), 32'({3{vq[i].stall}}));
      tick();
    end

    // Branch waits for an E producer, then picks the value up from M a cycle later.
    t = '{br: 1'b1, rw_e: 1'b1, wr_e: 5'd4, rs_d: 5'd4, default: '0};
    apply(t);
    #1;
    check("br_e_stall", 32'(stall_d), 32'd1);
    tick();
    t = '{br: 1'b1, rw_m: 1'b1, wr_m: 5'd4, rs_d: 5'd4, default: '0};
    apply(t);
    #1;
    check("br_m_nostall", 32'(stall_d), 32'd0);
    check("br_m_fwd_a_d", 32'(forward_a_d), 32'd1);
    tick();

    // Divide with an mfhi waiting in decode.
    t = '{mfhilo: 1'b1, default: '0};
    apply(t);
    md_start_e = 1'b1;
    md_is_div_e = 1'b1;
    #1;
    check("div_start_stall", 32'(stall_f), 32'd1);
    tick();
    md_start_e = 1'b0;
    busy_n = 0; first_busy = 0; done_k = 0; stall_bad = 0; stall_at_done = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      if (md_busy) begin
        busy_n++;
        if (first_busy == 0) first_busy = k;
      end
      if (md_done && done_k == 0) begin
        done_k = k;
        stall_at_done = stall_f;
      end
      if (md_busy && !stall_f) stall_bad++;
      tick();
    end
    check("div_first_busy", 32'(first_busy), 32'd1);
    check("div_busy_cycles", 32'(busy_n), 32'(DIV_N));
    check("div_done_cycle", 32'(done_k), 32'(DIV_N + 1));
    check("div_stall_in_busy", 32'(stall_bad), 32'd0);
    check("div_stall_at_done", 32'(stall_at_done), 32'd0);

    // Multiply abandoned by reset in its second BUSY cycle.
    apply(z);
    md_start_e = 1'b1;
    md_is_div_e = 1'b0;
    tick();
    md_start_e = 1'b0;
    tick();
    check("mul_busy_before_reset", 32'(md_busy), 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_busy", 32'(md_busy), 32'd0);
    check("async_reset_done", 32'(md_done), 32'd0);
    tick();
    reset = 1'b0;
    any_n = 0;
    for (int k = 0; k < 8; k++) begin
      if (md_busy || md_done) any_n++;
      tick();
    end
    check("no_done_after_abort", 32'(any_n), 32'd0);

    // Start already pending when reset releases: first edge must accept it.
    reset = 1'b1;
    #2;
    md_start_e = 1'b1;
    reset = 1'b0;
    tick();
    md_start_e = 1'b0;
    done_k = 0;
    for (int k = 1; k <= 10; k++) begin
      if (md_done && done_k == 0) done_k = k;
      tick();
    end
    check("mul_after_reset_done", 32'(done_k), 32'(MULT_N + 1));

    // Randomized traffic against the behavioural model.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    m_left = 0;
    m_done = 1'b0;
    for (int c = 0; c < 600; c++) begin
      t = rand_in();
      idle = (m_left == 0) && !m_done;
      st = idle && ($urandom_range(0, 3) == 0);
      dv = (st && $urandom_range(0, 3) == 0);
      apply(t);
      md_start_e = st;
      md_is_div_e = dv;
      #1;
      check("rnd_fa_e", 32'(forward_a_e), 32'(ref_fwd(t, t.rs_e)));
      check("rnd_fb_e", 32'(forward_b_e), 32'(ref_fwd(t, t.rt_e)));
      check("rnd_fa_d", 32'(forward_a_d), 32'(t.rs_d != 0 && t.rw_m && t.wr_m == t.rs_d));
      check("rnd_fb_d", 32'(forward_b_d), 32'(t.rt_d != 0 && t.rw_m && t.wr_m == t.rt_d));
      check("rnd_stall", 32'({stall_f, stall_d, flush_e}), 32'({3{ref_stall(t, m_left > 0, st)}}));
      check("rnd_busy", 32'(md_busy), 32'(m_left > 0));
      check("rnd_done", 32'(md_done), 32'(m_done));
      if (m_done) m_done = 1'b0;
      else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end else if (st) m_left = dv ? DIV_N : MULT_N;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
